// File: rtl/mod4051_reduce_ctrl.sv
// Sequential X mod 4051 reducer: walks X in 6-bit chunks through an external residue LUT.
// Optional zero-chunk skipping is enabled by defining MOD4051_SKIP_ZERO_EN.
module mod4051_reduce_ctrl #(
  parameter int unsigned X_WIDTH = 300
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [X_WIDTH-1:0] in_x,
  output logic [5:0]         lut_sel,
  output logic [5:0]         lut_x,
  input  logic [11:0]        lut_z,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [11:0]        out_z,
  output logic               out_err
);

  localparam int unsigned NCHUNK = X_WIDTH / 6;
  localparam logic [5:0]  K_LAST = 6'(NCHUNK - 1);
  localparam logic [12:0] MODV   = 13'd4051;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [5:0]         k_q, k_d;
  logic [11:0]        acc_q, acc_d;
  logic               err_q, err_d;
  logic [X_WIDTH-1:0] opnd_q, opnd_d;

  logic [5:0]  chunk;
  logic [12:0] sum;
  logic [11:0] acc_red;
  logic        lut_bad;
  logic        last;

  // The operand shifts down one chunk per RUN cycle, so the current chunk is always the low 6 bits.
  assign chunk   = opnd_q[5:0];
  assign sum     = {1'b0, acc_q} + {1'b0, lut_z};
  assign acc_red = (sum >= MODV) ? 12'(sum - MODV) : sum[11:0];
  assign lut_bad = (lut_z >= 12'd4051);

`ifdef MOD4051_SKIP_ZERO_EN
  logic rest_zero;
  assign rest_zero = (opnd_q[X_WIDTH-1:6] == '0);
  assign last      = rest_zero || (k_q == K_LAST);
`else
  assign last      = (k_q == K_LAST);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
      opnd_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      opnd_q  <= opnd_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc_d   = acc_q;
    err_d   = err_q;
    opnd_d  = opnd_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          opnd_d  = in_x;
          acc_d   = '0;
          err_d   = 1'b0;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
`ifdef MOD4051_SKIP_ZERO_EN
        if (chunk != 6'd0) begin
          acc_d = acc_red;
          err_d = err_q | lut_bad;
        end
`else
        acc_d = acc_red;
        err_d = err_q | lut_bad;
`endif
        opnd_d = opnd_q >> 6;
        if (last) begin
          state_d = DONE;
        end else begin
          k_d = 6'(k_q + 6'd1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_z     = (state_q == DONE) ? acc_q : 12'd0;
  assign out_err   = (state_q == DONE) & err_q;
  assign lut_sel   = (state_q == RUN) ? k_q : 6'd0;
  assign lut_x     = (state_q == RUN) ? chunk : 6'd0;

endmodule
